// File: rtl/impact_sram_seq.sv
// impact_sram_seq: read-access sequencer for the IMPACT SRAM bank.
// It accepts row-read requests on a valid/ready handshake. For each row it
// drives bitline precharge, then the word line, then sense enable, in a fixed
// order. It samples the BL/BLb pair and returns one result per row.
//
// Optional feature: define IMPACT_SEQ_SWEEP_EN to enable multi-row sweeps
// (rows addr..NWL-1 read back-to-back). When the macro is undefined, the
// sweep input is ignored and every request reads exactly one row.
//
// Ports:
//   C        clock, all state updates on the rising edge
//   RN       asynchronous active-low reset
//   req      request valid; a request is accepted when req & ready
//   addr     start row
//   sweep    1 = read addr..NWL-1, 0 = read a single row
//   ready    high only while idle (registered)
//   WL       one-hot word-line drive (registered)
//   PRE      bitline precharge enable (registered)
//   SAE      sense-amp enable (registered)
//   BL, BLb  differential bitline pair from the bank
//   rvalid   one-cycle result strobe
//   rdata    sensed bit (sampled BL); holds until the next rvalid
//   raddr    row of the current result; holds until the next rvalid
//   rerr     result invalid: illegal address, or BL == BLb at sense
module impact_sram_seq #(
  parameter int unsigned NWL     = 10,
  parameter int unsigned PRE_CYC = 2,
  parameter int unsigned WL_CYC  = 4
) (
  input  logic           C,
  input  logic           RN,
  input  logic           req,
  input  logic [3:0]     addr,
  input  logic           sweep,
  output logic           ready,
  output logic [NWL-1:0] WL,
  output logic           PRE,
  output logic           SAE,
  input  logic           BL,
  input  logic           BLb,
  output logic           rvalid,
  output logic           rdata,
  output logic [3:0]     raddr,
  output logic           rerr
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned AW    = 4;

  localparam logic [CNT_W-1:0] PRE_LOAD = CNT_W'(PRE_CYC - 1);
  localparam logic [CNT_W-1:0] WL_LOAD  = CNT_W'(WL_CYC - 1);
  localparam logic [AW-1:0]    LAST_ROW = AW'(NWL - 1);
  localparam logic [NWL-1:0]   WL_ONE   = NWL'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_WLON  = 3'd2,
    ST_SENSE = 3'd3,
    ST_RECOV = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [AW-1:0]    row, row_nxt;

  logic             rdata_nxt;
  logic [AW-1:0]    raddr_nxt;
  logic             rerr_nxt;

  logic             ready_nxt;
  logic [NWL-1:0]   wl_nxt;
  logic             pre_nxt;
  logic             sae_nxt;
  logic             rvalid_nxt;

`ifdef IMPACT_SEQ_SWEEP_EN
  logic             sweep_r, sweep_nxt;
`else
  logic             sweep_unused;
  assign sweep_unused = sweep;
`endif

  // Next-state, counter, row and result computation
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    row_nxt   = row;
    rdata_nxt = rdata;
    raddr_nxt = raddr;
    rerr_nxt  = rerr;
`ifdef IMPACT_SEQ_SWEEP_EN
    sweep_nxt = sweep_r;
`endif

    case (state)
      ST_IDLE: begin
        if (req) begin
          row_nxt = addr;
`ifdef IMPACT_SEQ_SWEEP_EN
          sweep_nxt = sweep;
`endif
          if (32'(addr) >= NWL) begin
            // The error result is published on entry to ERR.
            state_nxt = ST_ERR;
            rdata_nxt = 1'b0;
            raddr_nxt = addr;
            rerr_nxt  = 1'b1;
          end else begin
            state_nxt = ST_PRE;
            cnt_nxt   = PRE_LOAD;
          end
        end
      end

      ST_PRE: begin
        if (cnt == '0) begin
          state_nxt = ST_WLON;
          cnt_nxt   = WL_LOAD;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end

      ST_WLON: begin
        if (cnt == '0) begin
          state_nxt = ST_SENSE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end

      ST_SENSE: begin
        // The bitlines are sampled at the end of the sense cycle. The result
        // becomes visible with rvalid in RECOV.
        state_nxt = ST_RECOV;
        rdata_nxt = BL;
        raddr_nxt = row;
        rerr_nxt  = (BL == BLb);
      end

      ST_RECOV: begin
        state_nxt = ST_IDLE;
`ifdef IMPACT_SEQ_SWEEP_EN
        if (sweep_r && (row < LAST_ROW)) begin
          state_nxt = ST_PRE;
          cnt_nxt   = PRE_LOAD;
          row_nxt   = row + AW'(1);
        end
`endif
      end

      ST_ERR: begin
        state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output decode of the next state. Registering this decode keeps every
  // drive glitch-free. The PRE to WL hand-off switches on a single edge, so
  // precharge and a word line are never high in the same cycle.
  always_comb begin
    ready_nxt  = (state_nxt == ST_IDLE);
    pre_nxt    = (state_nxt == ST_PRE);
    sae_nxt    = (state_nxt == ST_SENSE);
    rvalid_nxt = (state_nxt == ST_RECOV) || (state_nxt == ST_ERR);
    wl_nxt     = '0;
    if ((state_nxt == ST_WLON) || (state_nxt == ST_SENSE)) begin
      wl_nxt = WL_ONE << row_nxt;
    end
  end

  // State and registered outputs
  always_ff @(posedge C or negedge RN) begin
    if (!RN) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      row    <= '0;
      ready  <= 1'b1;
      WL     <= '0;
      PRE    <= 1'b0;
      SAE    <= 1'b0;
      rvalid <= 1'b0;
      rdata  <= 1'b0;
      raddr  <= '0;
      rerr   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      row    <= row_nxt;
      ready  <= ready_nxt;
      WL     <= wl_nxt;
      PRE    <= pre_nxt;
      SAE    <= sae_nxt;
      rvalid <= rvalid_nxt;
      rdata  <= rdata_nxt;
      raddr  <= raddr_nxt;
      rerr   <= rerr_nxt;
    end
  end

`ifdef IMPACT_SEQ_SWEEP_EN
  // Sweep mode latched at acceptance
  always_ff @(posedge C or negedge RN) begin
    if (!RN) begin
      sweep_r <= 1'b0;
    end else begin
      sweep_r <= sweep_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_impact_sram_seq.sv
// tb_impact_sram_seq: directed self-checking bench for impact_sram_seq.
// Default parameters are used (NWL=10, PRE_CYC=2, WL_CYC=4), so each row
// period is 8 cycles. Inputs change and outputs are sampled on the falling
// clock edge. Cycle 0 is the cycle in which req is presented to an idle
// sequencer.
module tb_impact_sram_seq;

  localparam int unsigned NWL = 10;
`ifdef IMPACT_SEQ_SWEEP_EN
  localparam int SW_ROWS = 3;
`else
  localparam int SW_ROWS = 1;
`endif

  logic           C = 1'b0;
  logic           RN;
  logic           req;
  logic [3:0]     addr;
  logic           sweep;
  logic           ready;
  logic [NWL-1:0] WL;
  logic           PRE;
  logic           SAE;
  logic           BL;
  logic           BLb;
  logic           rvalid;
  logic           rdata;
  logic [3:0]     raddr;
  logic           rerr;

  int checks = 0;
  int errors = 0;

  impact_sram_seq dut (
    .C      (C),
    .RN     (RN),
    .req    (req),
    .addr   (addr),
    .sweep  (sweep),
    .ready  (ready),
    .WL     (WL),
    .PRE    (PRE),
    .SAE    (SAE),
    .BL     (BL),
    .BLb    (BLb),
    .rvalid (rvalid),
    .rdata  (rdata),
    .raddr  (raddr),
    .rerr   (rerr)
  );

  always #5 C = ~C;

  task automatic chk(input string tag, input int cyc, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d: observed 0x%0h expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  // Issues one request from an idle DUT, then checks ncyc cycles. Row r of a
  // sweep sees BL=blv[r] and BLb=blbv[r] during its own 8-cycle period.
  task automatic run_access(input logic [3:0] a, input logic sw, input int nrows,
                            input logic [2:0] blv, input logic [2:0] blbv,
                            input int ncyc);
    int r;
    int ph;
    logic [NWL-1:0] wl_e;
    chk("ready_c0", 0, 32'(ready), 32'(1));
    req   = 1'b1;
    addr  = a;
    sweep = sw;
    BL    = blv[0];
    BLb   = blbv[0];
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge C);
      req = 1'b0;
      r   = (k - 1) / 8;
      ph  = (k - 1) % 8 + 1;
      if (r < nrows) begin
        BL   = blv[2'(r)];
        BLb  = blbv[2'(r)];
        wl_e = (ph >= 3 && ph <= 7) ? (10'b1 << (32'(a) + 32'(r))) : '0;
        chk("pre",    k, 32'(PRE),    32'(ph <= 2));
        chk("wl",     k, 32'(WL),     32'(wl_e));
        chk("sae",    k, 32'(SAE),    32'(ph == 7));
        chk("ready",  k, 32'(ready),  32'(0));
        chk("rvalid", k, 32'(rvalid), 32'(ph == 8));
        if (ph == 8) begin
          chk("rdata", k, 32'(rdata), 32'(blv[2'(r)]));
          chk("raddr", k, 32'(raddr), 32'(a) + 32'(r));
          chk("rerr",  k, 32'(rerr),  32'(blv[2'(r)] == blbv[2'(r)]));
        end
      end else begin
        chk("idle_ready",  k, 32'(ready),  32'(1));
        chk("idle_rvalid", k, 32'(rvalid), 32'(0));
        chk("idle_wl",     k, 32'(WL),     32'(0));
        chk("idle_pre",    k, 32'(PRE),    32'(0));
        chk("idle_sae",    k, 32'(SAE),    32'(0));
        if (ph == 1 && r == nrows) begin
          chk("hold_rdata", k, 32'(rdata), 32'(blv[2'(nrows - 1)]));
          chk("hold_raddr", k, 32'(raddr), 32'(a) + 32'(nrows - 1));
        end
      end
    end
  endtask

  initial begin
    int res_cnt;
    int rv_e;

    RN    = 1'b0;
    req   = 1'b0;
    addr  = '0;
    sweep = 1'b0;
    BL    = 1'b0;
    BLb   = 1'b0;

    // Reset values while RN is held low
    repeat (2) @(negedge C);
    chk("rst_ready",  0, 32'(ready),  32'(1));
    chk("rst_wl",     0, 32'(WL),     32'(0));
    chk("rst_pre",    0, 32'(PRE),    32'(0));
    chk("rst_sae",    0, 32'(SAE),    32'(0));
    chk("rst_rvalid", 0, 32'(rvalid), 32'(0));
    chk("rst_rdata",  0, 32'(rdata),  32'(0));
    chk("rst_raddr",  0, 32'(raddr),  32'(0));
    chk("rst_rerr",   0, 32'(rerr),   32'(0));
    RN = 1'b1;
    @(negedge C);

    // Single read of row 3 with BL=1, BLb=0
    run_access(4'd3, 1'b0, 1, 3'b001, 3'b000, 10);
    // BL == BLb: the result is flagged invalid
    run_access(4'd0, 1'b0, 1, 3'b001, 3'b001, 10);
    // Top row, BL=0, BLb=1
    run_access(4'd9, 1'b0, 1, 3'b000, 3'b001, 10);

    // Illegal address 12: error result in cycle 1, ready again in cycle 2
    chk("ill_ready_c0", 0, 32'(ready), 32'(1));
    req  = 1'b1;
    addr = 4'd12;
    @(negedge C);
    req = 1'b0;
    chk("ill_rvalid", 1, 32'(rvalid), 32'(1));
    chk("ill_rerr",   1, 32'(rerr),   32'(1));
    chk("ill_raddr",  1, 32'(raddr),  32'(12));
    chk("ill_rdata",  1, 32'(rdata),  32'(0));
    chk("ill_wl",     1, 32'(WL),     32'(0));
    chk("ill_pre",    1, 32'(PRE),    32'(0));
    chk("ill_ready",  1, 32'(ready),  32'(0));
    @(negedge C);
    chk("ill_ready2",  2, 32'(ready),  32'(1));
    chk("ill_rvalid2", 2, 32'(rvalid), 32'(0));
    chk("ill_raddr2",  2, 32'(raddr),  32'(12));
    chk("ill_wl2",     2, 32'(WL),     32'(0));
    chk("ill_pre2",    2, 32'(PRE),    32'(0));
    @(negedge C);

    // Sweep from row 7; BL toggles per row (rows 7, 8, 9 read 1, 0, 1)
    run_access(4'd7, 1'b1, SW_ROWS, 3'b101, 3'b010, 8 * SW_ROWS + 2);

    // req held high: second acceptance in cycle 9. The addr changes while the
    // sequencer is busy must not affect the latched row.
    res_cnt = 0;
    chk("held_ready_c0", 0, 32'(ready), 32'(1));
    req   = 1'b1;
    addr  = 4'd2;
    sweep = 1'b0;
    BL    = 1'b0;
    BLb   = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge C);
      rv_e = (k == 8 || k == 17) ? 1 : 0;
      if (rvalid === 1'b1) res_cnt++;
      chk("held_rvalid", k, 32'(rvalid), 32'(rv_e));
      chk("held_ready",  k, 32'(ready),  32'(k == 9 || k >= 18));
      chk("held_pre",    k, 32'(PRE),    32'(k == 1 || k == 2 || k == 10 || k == 11));
      if (k == 8) chk("held_raddr1", k, 32'(raddr), 32'(2));
      if (k == 17) begin
        chk("held_raddr2", k, 32'(raddr), 32'(4));
        chk("held_rdata2", k, 32'(rdata), 32'(1));
        chk("held_rerr2",  k, 32'(rerr),  32'(0));
      end
      if (k >= 2 && k <= 8) addr = 4'd11;
      if (k == 9) begin
        addr = 4'd4;
        BL   = 1'b1;
        BLb  = 1'b0;
      end
      if (k >= 10) req = (k % 2 == 0) && (k < 17);
    end
    req = 1'b0;
    chk("held_results", 20, 32'(res_cnt), 32'(2));
    @(negedge C);

    // Reset asserted during WLON of row 5 in a sweep
    chk("rst5_ready_c0", 0, 32'(ready), 32'(1));
    req   = 1'b1;
    addr  = 4'd5;
    sweep = 1'b1;
    BL    = 1'b1;
    BLb   = 1'b0;
    repeat (4) @(negedge C);
    req = 1'b0;
    chk("rst5_wl_before", 4, 32'(WL), 32'(10'h020));
    #2;
    RN = 1'b0;
    #1;
    chk("rst5_wl",     4, 32'(WL),     32'(0));
    chk("rst5_pre",    4, 32'(PRE),    32'(0));
    chk("rst5_sae",    4, 32'(SAE),    32'(0));
    chk("rst5_rvalid", 4, 32'(rvalid), 32'(0));
    chk("rst5_ready",  4, 32'(ready),  32'(1));
    chk("rst5_raddr",  4, 32'(raddr),  32'(0));
    chk("rst5_rdata",  4, 32'(rdata),  32'(0));
    chk("rst5_rerr",   4, 32'(rerr),   32'(0));
    @(negedge C);
    RN = 1'b1;
    res_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge C);
      if (rvalid === 1'b1) res_cnt++;
      chk("post_rst_ready", k, 32'(ready), 32'(1));
      chk("post_rst_wl",    k, 32'(WL),    32'(0));
    end
    chk("post_rst_results", 30, 32'(res_cnt), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/impact_sram_seq.md
# impact_sram_seq

Read-access sequencer for the 10-word-line IMPACT SRAM bank. It accepts row-read requests over a valid/ready handshake and drives the bank's precharge, word-line and sense-enable controls in a fixed, glitch-free order. It samples the differential bitline pair (BL0/BLb0) and returns one result per row. It sits between the user-project control logic and the IMPACT_Sram macro, replacing direct pin-driven word-line control.

## Interface
Parameters:
- NWL, 10, number of word lines (rows); legal addresses are 0..NWL-1
- PRE_CYC, 2, precharge cycles per access (1..15)
- WL_CYC, 4, word-line-high cycles before sensing (1..15)

Ports:
- C  in  1  clock; all state updates on rising edge
- RN  in  1  reset, asynchronous, active-low
- req  in  1  request valid
- addr  in  4  start row
- sweep  in  1  1 = read rows addr..NWL-1 back-to-back; 0 = single row
- ready  out  1  high only in IDLE; request accepted when req & ready
- WL  out  NWL  one-hot word-line drive, registered
- PRE  out  1  bitline precharge enable, registered
- SAE  out  1  sense enable, registered
- BL  in  1  bitline from bank (BL0)
- BLb  in  1  complement bitline from bank (BLb0)
- rvalid  out  1  one-cycle result strobe
- rdata  out  1  sensed bit (BL sampled)
- raddr  out  4  row of current result
- rerr  out  1  result invalid: illegal address or BL==BLb

## Operation
- States: IDLE, PRE, WLON, SENSE, RECOV, ERR.
- IDLE: all drives 0. On req & ready, latch addr/sweep.
  - addr >= NWL → ERR.
  - Otherwise → PRE.
- PRE: PRE=1 for PRE_CYC cycles, then → WLON.
- WLON: WL[row]=1 for WL_CYC cycles, then → SENSE.
- SENSE: one cycle; WL[row]=1, SAE=1. BL/BLb sampled at the end of the cycle.
- RECOV: one cycle; all drives 0. rvalid=1, rdata=sampled BL, raddr=row, rerr=(BL==BLb).
  - If sweep and row < NWL-1: row+1 → PRE.
  - Else → IDLE.
- ERR: one cycle; rvalid=1, rerr=1, rdata=0, raddr=latched addr; → IDLE.
- Break-before-make: WL and PRE are never high in the same cycle, and at most one WL bit is high at any time.
- req while not ready is ignored; there is no queue.
- A single 4-bit down-counter times both PRE and WLON and is reloaded on each state entry.
- rdata, raddr and rerr hold their value until the next rvalid.

## Timing
- Cycle 0 is the acceptance cycle (req & ready).
- Defaults, single read:
  - cycles 1-2 PRE
  - cycles 3-6 WL
  - cycle 7 SENSE
  - cycle 8 RECOV with rvalid
  - cycle 9 ready=1, and a new request may be accepted in that cycle
- Latency req→rvalid = PRE_CYC + WL_CYC + 2 cycles.
- Sweep: the next row's PRE starts in the cycle after RECOV. Per-row period = PRE_CYC + WL_CYC + 2.
- Illegal address: rvalid/rerr in cycle 1, ready in cycle 2.
- Reset values:
  - WL=0, PRE=0, SAE=0, rvalid=0, rdata=0, raddr=0, rerr=0
  - ready=1 (IDLE)
- RN low at any point, including mid-sweep or during SENSE: all outputs go to their reset values immediately (asynchronously). No result is emitted for the aborted row, and the FSM restarts in IDLE.

## Configuration
- IMPACT_SEQ_SWEEP_EN defined: sweep behaves as described.
- Not defined: sweep input is ignored and treated as 0. Every request reads exactly one row; the row-increment logic is removed.

## Test plan
- Reset, then req, addr=3, sweep=0, BL=1, BLb=0 → PRE cycles 1-2; WL=10'h008 cycles 3-7; SAE cycle 7; rvalid cycle 8 with rdata=1, raddr=3, rerr=0; ready cycle 9.
- req addr=12 → cycle 1 rvalid=1, rerr=1, raddr=12; WL/PRE never asserted; ready cycle 2.
- Sweep from addr=7, BL toggling per row → three results, raddr 7, 8, 9, spaced 8 cycles apart; WL walks 0x080→0x100→0x200; then IDLE. Without IMPACT_SEQ_SWEEP_EN: one result only, raddr=7.
- BL=BLb=1 during SENSE → rerr=1 on that result.
- req held high continuously → second acceptance exactly in cycle 9; req pulses during busy cycles 1-8 produce no extra result.
- RN asserted during WLON of row 5 in a sweep → WL/PRE/SAE/rvalid=0 immediately and ready=1; no result for row 5 and no later rows.
